// File: rtl/seg7_pkg.sv
// seg7_pkg: register map, bus size encodings, converter states and STATUS bit layout
// shared by seg7_mmio and bin2bcd_seq.
package seg7_pkg;

    localparam logic [63:0] DATA_ADDR = 64'h1024;
    localparam logic [63:0] CTRL_ADDR = 64'h1028;

    localparam logic [1:0] SZ_BYTE  = 2'b00;
    localparam logic [1:0] SZ_HALF  = 2'b01;
    localparam logic [1:0] SZ_WORD  = 2'b10;
    localparam logic [1:0] SZ_DWORD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } bcd_state_t;

    localparam int STAT_BUSY = 0;
    localparam int STAT_OVF  = 1;
    localparam int STAT_MODE = 2;

    // One double-dabble correction step: every BCD digit >= 5 gets +3 before the shift.
    function automatic logic [19:0] bcd_add3(input logic [19:0] acc);
        logic [19:0] r;
        r = acc;
        for (int i = 0; i < 5; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential 16-bit binary to 5-digit BCD converter (double dabble).
// Latency: start edge + 16 SHIFT cycles, result valid with done during the LOAD cycle.
// Backpressure: none; start while busy discards the running conversion and restarts.
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    bcd_state_t  state_q, state_d;
    logic [15:0] sh_q, sh_d;
    logic [19:0] acc_q, acc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] acc_adj;

    assign acc_adj = bcd_add3(acc_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (start) begin
            state_d = ST_SHIFT;
            sh_d    = bin;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    {acc_d, sh_d} = {acc_adj[18:0], sh_q, 1'b0};
                    cnt_d         = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_d = ST_LOAD;
                    end
                end
                ST_LOAD: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_LOAD);
    assign bcd  = acc_q;

endmodule

// File: rtl/seg7_mmio.sv
// seg7_mmio: DATA/CTRL registers driving seg7_disp4; BCD mode built only with SEG7_MMIO_BCD_EN.
// Latency: hex write shows after one edge, decimal write after 17 edges; rdata is combinational.
// Backpressure: none; halfword writes always land, a write mid-conversion restarts it.
module seg7_mmio
    import seg7_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
    input  logic        rw,
    input  logic [1:0]  word,
    output logic [63:0] rdata,
    output logic [15:0] digitals,
    output logic        busy
);

    logic        wr_half, data_wr, ctrl_wr;
    logic [15:0] raw;
    logic        mode, ovf;
    logic        unused_wdata;

    assign wr_half      = rw && (word == SZ_HALF);
    assign data_wr      = wr_half && (addr == DATA_ADDR);
    assign ctrl_wr      = wr_half && (addr == CTRL_ADDR);
    assign unused_wdata = ^wdata[63:16];

`ifdef SEG7_MMIO_BCD_EN
    logic        conv_start, conv_busy, conv_done, conv_ok, conv_sat;
    logic [15:0] conv_bin;
    logic [19:0] conv_bcd;

    // CTRL writes reconvert the held raw value; DATA writes convert the new one.
    assign conv_start = (data_wr && mode) || (ctrl_wr && wdata[0]);
    assign conv_bin   = data_wr ? wdata[15:0] : raw;
    // Leaving decimal mode orphans the converter; its late result and busy are masked.
    assign conv_ok    = conv_done && mode;
    assign conv_sat   = (conv_bcd[19:16] != 4'd0);
    assign busy       = conv_busy && mode;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            raw      <= '0;
            mode     <= 1'b0;
            ovf      <= 1'b0;
            digitals <= '0;
        end else begin
            if (data_wr) raw  <= wdata[15:0];
            if (ctrl_wr) mode <= wdata[0];
            // Saturation wins over a same-edge OVF_CLR.
            if (conv_ok && conv_sat)      ovf <= 1'b1;
            else if (ctrl_wr && wdata[1]) ovf <= 1'b0;
            if (data_wr && !mode)
                digitals <= wdata[15:0];
            else if (ctrl_wr && !wdata[0])
                digitals <= raw;
            else if (conv_ok && !data_wr && !ctrl_wr)
                digitals <= conv_sat ? 16'h9999 : conv_bcd[15:0];
        end
    end
`else
    assign mode = 1'b0;
    assign ovf  = 1'b0;
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw      <= '0;
            digitals <= '0;
        end else if (data_wr) begin
            raw      <= wdata[15:0];
            digitals <= wdata[15:0];
        end
    end
`endif

    always_comb begin
        rdata = '0;
        if (!rw) begin
            if (addr == DATA_ADDR) begin
                rdata[15:0] = raw;
            end else if (addr == CTRL_ADDR) begin
                rdata[STAT_MODE] = mode;
                rdata[STAT_OVF]  = ovf;
                rdata[STAT_BUSY] = busy;
            end
        end
    end

endmodule

// File: tb/tb_seg7_mmio.sv
// tb_seg7_mmio: directed plus random bus traffic; a decimal-arithmetic model fills a
// scoreboard queue each cycle and a negedge monitor pops and compares DUT outputs.
module tb_seg7_mmio;

`ifdef SEG7_MMIO_BCD_EN
    localparam bit BCD_EN = 1'b1;
`else
    localparam bit BCD_EN = 1'b0;
`endif

    localparam logic [63:0] A_DATA = 64'h1024;
    localparam logic [63:0] A_CTRL = 64'h1028;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] addr = '0;
    logic [63:0] wdata = '0;
    logic        rw = 1'b0;
    logic [1:0]  word = 2'b01;
    logic [63:0] rdata;
    logic [15:0] digitals;
    logic        busy;

    seg7_mmio dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .wdata    (wdata),
        .rw       (rw),
        .word     (word),
        .rdata    (rdata),
        .digitals (digitals),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] dig;
        logic        bsy;
        logic [63:0] rd;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference state: what the display logically holds, plus a pending conversion.
    logic [15:0] m_raw = '0;
    logic [15:0] m_dig = '0;
    logic        m_mode = 1'b0;
    logic        m_ovf = 1'b0;
    logic        m_act = 1'b0;
    int          m_rem = 0;
    int          m_val = 0;

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic start_conv(input logic [15:0] v);
        m_act = 1'b1;
        m_rem = 17;
        m_val = int'(v);
    endtask

    // Apply the inputs the DUT sampled on the edge that just happened.
    task automatic model_edge();
        bit          dw, cw, fin, sat;
        logic [15:0] wd;
        if (rst) begin
            m_raw = '0; m_dig = '0; m_mode = 1'b0; m_ovf = 1'b0;
            m_act = 1'b0; m_rem = 0; m_val = 0;
            return;
        end
        wd  = wdata[15:0];
        dw  = rw && (word == 2'b01) && (addr == A_DATA);
        cw  = rw && (word == 2'b01) && (addr == A_CTRL);
        fin = m_act && (m_rem == 1);
        sat = (m_val >= 10000);
        if (fin) begin
            m_act = 1'b0;
            if (sat) m_ovf = 1'b1;
        end else if (m_act) begin
            m_rem--;
        end
        if (!BCD_EN) begin
            if (dw) begin
                m_raw = wd;
                m_dig = wd;
            end
            return;
        end
        if (dw) begin
            m_raw = wd;
            if (m_mode) start_conv(wd);
            else        m_dig = wd;
        end
        if (cw) begin
            if (wd[1] && !(fin && sat)) m_ovf = 1'b0;
            m_mode = wd[0];
            if (m_mode) start_conv(m_raw);
            else begin
                m_dig = m_raw;
                m_act = 1'b0;
            end
        end
        if (fin && !dw && !cw) m_dig = sat ? 16'h9999 : to_bcd(m_val);
    endtask

    task automatic push_expect();
        exp_t e;
        e.dig = m_dig;
        e.bsy = BCD_EN && m_act;
        e.rd  = '0;
        if (!rw) begin
            if (addr == A_DATA)      e.rd = {48'b0, m_raw};
            else if (addr == A_CTRL) e.rd = {61'b0, m_mode, m_ovf, e.bsy};
        end
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic cycle(input logic r, input logic [63:0] a, input logic [63:0] d,
                         input logic w, input logic [1:0] sz);
        @(posedge clk);
        model_edge();
        #1;
        rst = r; addr = a; wdata = d; rw = w; word = sz;
        cyc++;
        push_expect();
    endtask

    task automatic wr(input logic [63:0] a, input logic [15:0] d);
        cycle(1'b0, a, {48'b0, d}, 1'b1, 2'b01);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, (i % 2) ? A_CTRL : A_DATA, '0, 1'b0, 2'b01);
    endtask

    task automatic rand_cycle();
        logic [63:0] a, d;
        logic        w, r;
        logic [1:0]  sz;
        case ($urandom_range(0, 3))
            0:       a = A_DATA;
            1:       a = A_CTRL;
            2:       a = 64'h1020;
            default: a = {$urandom, $urandom};
        endcase
        d = {$urandom, $urandom};
        if ($urandom_range(0, 1) == 0) d[15:0] = 16'($urandom_range(0, 9999));
        w  = ($urandom_range(0, 9) == 0);
        sz = ($urandom_range(0, 3) != 0) ? 2'b01 : 2'($urandom_range(0, 3));
        r  = ($urandom_range(0, 399) == 0);
        cycle(r, a, d, w, sz);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp,
                         input int c);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, c, got, exp);
        end
    endtask

    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("digitals", {48'b0, digitals}, {48'b0, e.dig}, e.cyc);
                check("busy", {63'b0, busy}, {63'b0, e.bsy}, e.cyc);
                check("rdata", rdata, e.rd, e.cyc);
            end
        end
    end

    initial begin
        cycle(1'b1, A_CTRL, '0, 1'b0, 2'b01);
        cycle(1'b1, A_DATA, '0, 1'b0, 2'b01);
        idle(2);
        // Hex display and readback.
        wr(A_DATA, 16'h1234);
        idle(2);
        // Decimal conversion of 1234.
        wr(A_CTRL, 16'h0001);
        wr(A_DATA, 16'h04D2);
        idle(20);
        // Overflow saturation, then clear.
        wr(A_DATA, 16'h2710);
        idle(20);
        wr(A_CTRL, 16'h0003);
        idle(2);
        // Restart mid-conversion: 99 must never appear.
        wr(A_DATA, 16'h0063);
        idle(5);
        wr(A_DATA, 16'h0007);
        idle(20);
        // Ignored accesses.
        cycle(1'b0, A_DATA, 64'hFFFF, 1'b1, 2'b00);
        cycle(1'b0, 64'h1020, 64'hAAAA, 1'b1, 2'b01);
        cycle(1'b0, A_DATA, 64'h5555, 1'b1, 2'b10);
        idle(2);
        // OVF_CLR on the saturating LOAD edge keeps OVF set.
        wr(A_DATA, 16'hFFFF);
        idle(16);
        wr(A_CTRL, 16'h0003);
        idle(20);
        // Leaving decimal mode mid-conversion redisplays raw in hex.
        wr(A_CTRL, 16'h0003);
        wr(A_DATA, 16'h0042);
        idle(5);
        wr(A_CTRL, 16'h0000);
        idle(20);
        // Reset during SHIFT, then an immediate hex write.
        wr(A_CTRL, 16'h0001);
        wr(A_DATA, 16'h0100);
        idle(4);
        cycle(1'b1, A_CTRL, '0, 1'b0, 2'b01);
        idle(2);
        wr(A_DATA, 16'hBEEF);
        idle(2);
        for (int i = 0; i < 3000; i++) rand_cycle();
        idle(20);
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
